// File: rtl/ccx_max_pkg.sv
// ccx_max_pkg: widths shared by the ccx2max CPX deserializer and PCX serializer
package ccx_max_pkg;
   localparam int CPX_WIDTH   = 145;
   localparam int PCX_WIDTH   = 124;
   localparam int MAX_D_WIDTH = 32;
   localparam int CPX_WORDS   = (CPX_WIDTH + MAX_D_WIDTH - 1) / MAX_D_WIDTH;
   localparam int CPX_LAST_W  = CPX_WIDTH - (CPX_WORDS - 1) * MAX_D_WIDTH;
   typedef logic [CPX_WIDTH-1:0] cpx_pkt_t;
endpackage

// File: rtl/ccx_pkt_fifo.sv
// ccx_pkt_fifo: synchronous packet FIFO with occupancy count
// Ports: clk/rst (sync, active-high), i_push/i_data write, i_pop read,
//        o_data head entry, o_count occupancy, o_full/o_empty flags.
module ccx_pkt_fifo #(
   parameter int WIDTH = 145,
   parameter int DEPTH = 2,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic [CW-1:0]    o_count,
   output logic             o_full,
   output logic             o_empty
);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
         end
         if (i_pop) r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
endmodule

// File: rtl/max2cpx_deser.sv
// max2cpx_deser: packs 32-bit Maxeler CPX stream words into 145-bit CPX packets for the core
// Ports: gclk/reset (sync, active-high); max_cpx_valid/max_cpx_data stream in;
//        max_cpx_stall host backpressure; cpx_spc_data_rdy_cx2 one-cycle packet pulse;
//        cpx_spc_data_cx2 packet (held between pulses); cpx_overflow sticky drop flag.
module max2cpx_deser
   import ccx_max_pkg::*;
#(
   parameter int BUF_DEPTH = 2,
   parameter int MIN_GAP   = 1
) (
   input  logic                   gclk,
   input  logic                   reset,
   input  logic                   max_cpx_valid,
   input  logic [MAX_D_WIDTH-1:0] max_cpx_data,
   output logic                   max_cpx_stall,
   output logic                   cpx_spc_data_rdy_cx2,
   output logic [CPX_WIDTH-1:0]   cpx_spc_data_cx2,
   output logic                   cpx_overflow
);
   localparam int CW    = $clog2(BUF_DEPTH + 1);
   localparam int GW    = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
   localparam int IW    = $clog2(CPX_WORDS);
   localparam int ASM_W = CPX_WIDTH - CPX_LAST_W;
   logic [ASM_W-1:0] r_asm;
   logic [IW-1:0]    r_word_idx;
   logic [GW-1:0]    r_gap;
   logic             w_accept;
   logic             w_last;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [CW-1:0]    w_count;
   logic [CW-1:0]    w_occ_next;
   cpx_pkt_t         w_pkt;
   cpx_pkt_t         w_head;
   assign w_accept   = max_cpx_valid & ~max_cpx_stall;
   assign w_last     = (r_word_idx == IW'(CPX_WORDS - 1));
   // full is unreachable while stall is honoured; the guard keeps the FIFO consistent anyway
   assign w_push     = w_accept & w_last & ~w_full;
   assign w_pop      = ~w_empty & (r_gap == '0);
   // the last word is never stored: it is merged straight into the pushed packet
   assign w_pkt      = {max_cpx_data[CPX_LAST_W-1:0], r_asm};
   assign w_occ_next = w_count + CW'(w_push) - CW'(w_pop);
   ccx_pkt_fifo #(.WIDTH(CPX_WIDTH), .DEPTH(BUF_DEPTH)) u_fifo (
      .clk     (gclk),
      .rst     (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_pkt),
      .o_data  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
   always_ff @(posedge gclk) begin
      if (reset) begin
         r_asm                <= '0;
         r_word_idx           <= '0;
         r_gap                <= '0;
         max_cpx_stall        <= 1'b0;
         cpx_spc_data_rdy_cx2 <= 1'b0;
         cpx_spc_data_cx2     <= '0;
         cpx_overflow         <= 1'b0;
      end else begin
         if (w_accept) begin
            if (w_last) begin
               r_word_idx <= '0;
            end else begin
               r_asm[int'(r_word_idx) * MAX_D_WIDTH +: MAX_D_WIDTH] <= max_cpx_data;
               r_word_idx <= r_word_idx + 1'b1;
            end
         end
         if (max_cpx_valid & max_cpx_stall) cpx_overflow <= 1'b1;
         // stall reflects occupancy after this cycle's push/pop so the host sees it before the next word
         max_cpx_stall        <= (w_occ_next == CW'(BUF_DEPTH));
         cpx_spc_data_rdy_cx2 <= w_pop;
         if (w_pop) cpx_spc_data_cx2 <= w_head;
         r_gap <= w_pop ? GW'(MIN_GAP) : (r_gap != '0) ? r_gap - 1'b1 : r_gap;
      end
   end
endmodule

// File: tb/tb_max2cpx_deser.sv
// tb_max2cpx_deser: scoreboard bench driving three deserializers (MIN_GAP 1, 0, 6) with one stream
module tb_max2cpx_deser;
   localparam int N = 3;
   function automatic int gap_of(input int i);
      return (i == 0) ? 1 : (i == 1) ? 0 : 6;
   endfunction
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         vld = 1'b0;
   logic [31:0]  dat = '0;
   logic         stall [N];
   logic         rdy [N];
   logic         ovf [N];
   logic [144:0] pdata [N];
   int           m_n [N];
   int           m_occ [N];
   int           m_gap [N];
   bit           m_rst [N];
   bit           m_rdy [N];
   bit           m_stall [N];
   bit           m_ovf [N];
   logic [159:0] m_acc [N];
   logic [144:0] exp_q [N][$];
   logic [144:0] last [N];
   logic [31:0]  w1 [5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h0001ABCD};
   int           n_checks = 0;
   int           n_errors = 0;
   bit           started = 1'b0;
   bit           done = 1'b0;
   bit           timeout = 1'b0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < N; g++) begin : gi
      max2cpx_deser #(.BUF_DEPTH(2), .MIN_GAP(gap_of(g))) dut (
         .gclk                 (clk),
         .reset                (rst),
         .max_cpx_valid        (vld),
         .max_cpx_data         (dat),
         .max_cpx_stall        (stall[g]),
         .cpx_spc_data_rdy_cx2 (rdy[g]),
         .cpx_spc_data_cx2     (pdata[g]),
         .cpx_overflow         (ovf[g])
      );
   end
   // reference model: words collected into a packet, buffer tracked as an occupancy count
   always @(posedge clk) begin
      bit p;
      started = 1'b1;
      for (int i = 0; i < N; i++) begin
         p = 1'b0;
         if (rst) begin
            m_rst[i] = 1'b1;
            m_n[i] = 0;
            m_occ[i] = 0;
            m_gap[i] = 0;
            m_rdy[i] = 1'b0;
            m_stall[i] = 1'b0;
            m_ovf[i] = 1'b0;
            m_acc[i] = '0;
            exp_q[i].delete();
         end else begin
            m_rst[i] = 1'b0;
            if (vld && m_stall[i]) m_ovf[i] = 1'b1;
            if (vld && !m_stall[i]) begin
               m_acc[i][32*m_n[i] +: 32] = dat;
               m_n[i]++;
               if (m_n[i] == 5) begin
                  p = 1'b1;
                  m_n[i] = 0;
               end
            end
            m_rdy[i] = (m_occ[i] > 0) && (m_gap[i] == 0);
            if (m_rdy[i]) begin
               m_occ[i]--;
               m_gap[i] = gap_of(i);
            end else if (m_gap[i] > 0) begin
               m_gap[i]--;
            end
            if (p) begin
               m_occ[i]++;
               exp_q[i].push_back(m_acc[i][144:0]);
            end
            m_stall[i] = (m_occ[i] == 2);
         end
      end
   end
   task automatic cmp(input string nm, input int i, input logic [144:0] act, input logic [144:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, i, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < N; i++) begin
            if (m_rst[i]) begin
               cmp("rst_rdy", i, 145'(rdy[i]), '0);
               cmp("rst_stall", i, 145'(stall[i]), '0);
               cmp("rst_ovf", i, 145'(ovf[i]), '0);
               cmp("rst_data", i, pdata[i], '0);
               last[i] = '0;
            end else begin
               cmp("rdy", i, 145'(rdy[i]), 145'(m_rdy[i]));
               cmp("stall", i, 145'(stall[i]), 145'(m_stall[i]));
               cmp("overflow", i, 145'(ovf[i]), 145'(m_ovf[i]));
               if (rdy[i] === 1'b1 && exp_q[i].size() > 0) begin
                  last[i] = exp_q[i].pop_front();
                  cmp("pkt", i, pdata[i], last[i]);
               end else begin
                  cmp("hold", i, pdata[i], last[i]);
               end
            end
         end
      end
      if (done) begin
         for (int i = 0; i < N; i++) cmp("undelivered", i, 145'(exp_q[i].size()), '0);
         cmp("stall_timeout", 0, 145'(timeout), '0);
         $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
         $finish;
      end
   end
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         vld = 1'b0;
      end
   endtask
   task automatic send(input logic [31:0] w, input bit polite);
      int t;
      t = 0;
      @(negedge clk);
      while (polite && stall[2] && t < 100) begin
         vld = 1'b0;
         t++;
         @(negedge clk);
      end
      if (t >= 100) timeout = 1'b1;
      vld = 1'b1;
      dat = w;
   endtask
   initial begin
      int t;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      foreach (w1[k]) send(w1[k], 1'b1);
      idle(8);
      repeat (15) send($urandom(), 1'b1);
      idle(1);
      t = 0;
      do begin
         @(negedge clk);
         vld = 1'b1;
         dat = $urandom();
         t++;
      end while (!stall[2] && t < 60);
      if (!stall[2]) timeout = 1'b1;
      @(negedge clk);
      vld = 1'b1;
      dat = $urandom();
      idle(40);
      repeat (3) send($urandom(), 1'b1);
      @(negedge clk);
      vld = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) send($urandom(), 1'b1);
      idle(8);
      repeat (4) send($urandom(), 1'b1);
      send(32'hFFFFFFFF, 1'b1);
      idle(8);
      repeat (40) send($urandom(), 1'b1);
      idle(4);
      repeat (300) begin
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 6)));
         send($urandom(), $urandom_range(0, 15) != 0);
      end
      idle(80);
      done = 1'b1;
   end
endmodule
